// File: rtl/hybrid_misr_pkg.sv
// Shared definitions for the hybrid-row output signature stage.
// Holds the run-state encoding, the default MISR polynomial/seed/counter
// width, and a pure single-step MISR function at the default width so that
// any model of the compactor uses exactly the same update rule.
package hybrid_misr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int                MISR_W    = 16;
  localparam logic [MISR_W-1:0] DEF_POLY  = 16'h1021;
  localparam logic [MISR_W-1:0] DEF_SEED  = 16'h0000;
  localparam int                DEF_CNT_W = 12;

  // One Galois MISR step: shift left, fold in feedback from the MSB xor the
  // incoming bit.
  function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] cur,
                                                   input logic              din);
    logic fb;
    fb = cur[MISR_W-1] ^ din;
    return {cur[MISR_W-2:0], 1'b0} ^ (fb ? DEF_POLY : '0);
  endfunction

endpackage

// File: rtl/hybrid_misr_core.sv
// Signature register of the output MISR.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset, loads SEED
//   load   - synchronous reload of SEED (start of a run), wins over en
//   en     - advance the signature by one step using din
//   din    - serial bit folded into the signature
//   sig    - current signature value
module hybrid_misr_core
  import hybrid_misr_pkg::*;
#(
  parameter int               SIG_W = MISR_W,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEF_SEED)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic             din,
  output logic [SIG_W-1:0] sig
);

  logic             fb;
  logic [SIG_W-1:0] sig_next;

  // Galois update: feedback is the outgoing MSB xor the new bit.
  always_comb begin
    fb       = sig[SIG_W-1] ^ din;
    sig_next = {sig[SIG_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= SEED;
    end else if (load) begin
      sig <= SEED;
    end else if (en) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/hybrid_out_misr.sv
// Output signature stage for the hybrid-row test netlist.
// Compacts the netlist's single-bit result into a MISR over a window of
// win_len valid samples, then compares the final signature to exp_sig.
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset
//   start    - begin a run (only honoured in IDLE)
//   win_len  - number of valid samples in the window, latched on start
//   exp_sig  - expected signature, sampled during the DONE cycle
//   data_in  - result bit to compact
//   data_vld - data_in is valid this cycle
//   busy     - run in progress (CAPTURE or DONE)
//   done     - one-cycle pulse when the final signature is on sig
//   sig      - running/final signature, held after the run
//   pass     - final signature matched exp_sig; held until the next start
module hybrid_out_misr
  import hybrid_misr_pkg::*;
#(
  parameter int               SIG_W = MISR_W,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEF_SEED),
  parameter int               CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] win_len,
  input  logic [SIG_W-1:0] exp_sig,
  input  logic             data_in,
  input  logic             data_vld,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] sig,
  output logic             pass
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pass_q;
  logic             sig_load;
  logic             sig_en;
  logic             last_sample;

  hybrid_misr_core #(
    .SIG_W(SIG_W),
    .POLY (POLY),
    .SEED (SEED)
  ) u_core (
    .clk  (clk),
    .rst_n(rst_n),
    .load (sig_load),
    .en   (sig_en),
    .din  (data_in),
    .sig  (sig)
  );

  // Next-state decode. A zero-length window skips CAPTURE entirely so the
  // run still produces exactly one done pulse with the seed as signature.
  // The window ends on cnt == len-1, so the counter never has to wrap.
  always_comb begin
    state_d     = state_q;
    sig_load    = 1'b0;
    sig_en      = 1'b0;
    last_sample = (cnt_q == (len_q - CNT_ONE));
    case (state_q)
      IDLE: begin
        if (start) begin
          sig_load = 1'b1;
          state_d  = (win_len == '0) ? DONE : CAPTURE;
        end
      end
      CAPTURE: begin
        if (data_vld) begin
          sig_en = 1'b1;
          if (last_sample) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Window length/count and the registered compare. pass is cleared on an
  // accepted start so a stale result never survives into a new run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q  <= '0;
      cnt_q  <= '0;
      pass_q <= 1'b0;
    end else begin
      if (sig_load) begin
        len_q  <= win_len;
        cnt_q  <= '0;
        pass_q <= 1'b0;
      end else if (sig_en) begin
        cnt_q <= cnt_q + CNT_ONE;
      end
      if (state_q == DONE) begin
        pass_q <= (sig == exp_sig);
      end
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign pass = pass_q;

endmodule

// File: tb/tb_hybrid_out_misr.sv
// Directed bench for hybrid_out_misr: inputs change and outputs are checked
// on the falling clock edge, away from the rising edge the DUT uses.
module tb_hybrid_out_misr;
  import hybrid_misr_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] win_len;
  logic [15:0] exp_sig;
  logic        data_in;
  logic        data_vld;
  logic        busy;
  logic        done;
  logic [15:0] sig;
  logic        pass;

  int checks;
  int errors;

  hybrid_out_misr dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .win_len (win_len),
    .exp_sig (exp_sig),
    .data_in (data_in),
    .data_vld(data_vld),
    .busy    (busy),
    .done    (done),
    .sig     (sig),
    .pass    (pass)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic st, input logic [11:0] wl,
                               input logic vld, input logic din);
    start    = st;
    win_len  = wl;
    data_vld = vld;
    data_in  = din;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] model;
    logic        bit_r;
    logic        vld_r;
    int          accepted;
    int          early_done;
    int          budget;

    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    exp_sig = 16'h0000;
    applyStimulus(1'b0, 12'd0, 1'b0, 1'b0);

    // Reset values.
    cycle();
    cycle();
    checkOutput("rst_sig", sig, 16'h0000);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_pass", pass, 1'b0);
    rst_n = 1'b1;

    // Single-sample window: 1 -> 0x1021.
    $display("[TB] window of one sample");
    exp_sig = 16'h1021;
    applyStimulus(1'b1, 12'd1, 1'b0, 1'b0);
    cycle();
    checkOutput("w1_busy", busy, 1'b1);
    checkOutput("w1_done_early", done, 1'b0);
    applyStimulus(1'b0, 12'd1, 1'b1, 1'b1);
    cycle();
    checkOutput("w1_done", done, 1'b1);
    checkOutput("w1_sig", sig, 16'h1021);
    applyStimulus(1'b0, 12'd1, 1'b0, 1'b0);
    cycle();
    checkOutput("w1_done_once", done, 1'b0);
    checkOutput("w1_busy_idle", busy, 1'b0);
    checkOutput("w1_pass", pass, 1'b1);

    // Two samples with a stall gap: 1,1 -> 0x3063; matching and wrong expected.
    for (int r = 0; r < 2; r++) begin
      $display("[TB] window of two samples, run %0d", r);
      exp_sig = (r == 0) ? 16'h3063 : 16'h3064;
      applyStimulus(1'b1, 12'd2, 1'b0, 1'b0);
      cycle();
      checkOutput("w2_pass_cleared", pass, 1'b0);
      applyStimulus(1'b0, 12'd2, 1'b1, 1'b1);
      cycle();
      checkOutput("w2_sig_first", sig, 16'h1021);
      applyStimulus(1'b0, 12'd2, 1'b0, 1'b0);
      for (int g = 0; g < 3; g++) begin
        cycle();
        checkOutput("w2_gap_done", done, 1'b0);
        checkOutput("w2_gap_sig", sig, 16'h1021);
      end
      applyStimulus(1'b0, 12'd2, 1'b1, 1'b1);
      cycle();
      checkOutput("w2_done", done, 1'b1);
      checkOutput("w2_sig", sig, 16'h3063);
      applyStimulus(1'b0, 12'd2, 1'b0, 1'b0);
      cycle();
      checkOutput("w2_done_once", done, 1'b0);
      checkOutput("w2_pass", pass, (r == 0) ? 1'b1 : 1'b0);
    end

    // Zero-length window: done straight away, signature stays at seed.
    for (int r = 0; r < 2; r++) begin
      $display("[TB] zero-length window, run %0d", r);
      exp_sig = (r == 0) ? 16'h0000 : 16'h0001;
      applyStimulus(1'b1, 12'd0, 1'b0, 1'b0);
      cycle();
      checkOutput("w0_done", done, 1'b1);
      checkOutput("w0_sig", sig, 16'h0000);
      applyStimulus(1'b0, 12'd0, 1'b0, 1'b0);
      cycle();
      checkOutput("w0_done_once", done, 1'b0);
      checkOutput("w0_pass", pass, (r == 0) ? 1'b1 : 1'b0);
    end

    // start held high (with a different win_len) through CAPTURE and DONE.
    // Data 1,0,1 -> 0x1021, 0x2042, 0x50A5.
    $display("[TB] start ignored while busy");
    exp_sig = 16'h50A5;
    applyStimulus(1'b1, 12'd3, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b1, 12'd1, 1'b1, 1'b1);
    cycle();
    checkOutput("ign_done_s1", done, 1'b0);
    checkOutput("ign_sig_s1", sig, 16'h1021);
    applyStimulus(1'b1, 12'd1, 1'b1, 1'b0);
    cycle();
    checkOutput("ign_done_s2", done, 1'b0);
    checkOutput("ign_sig_s2", sig, 16'h2042);
    applyStimulus(1'b1, 12'd1, 1'b1, 1'b1);
    cycle();
    checkOutput("ign_done", done, 1'b1);
    checkOutput("ign_sig", sig, 16'h50A5);
    applyStimulus(1'b1, 12'd1, 1'b0, 1'b0);
    cycle();
    checkOutput("ign_busy_after_done", busy, 1'b0);
    checkOutput("ign_pass", pass, 1'b1);
    applyStimulus(1'b0, 12'd1, 1'b0, 1'b0);

    // Valid data while idle must not touch the signature.
    $display("[TB] data_vld while idle");
    applyStimulus(1'b0, 12'd1, 1'b1, 1'b1);
    cycle();
    cycle();
    checkOutput("idle_vld_sig", sig, 16'h50A5);
    checkOutput("idle_vld_busy", busy, 1'b0);
    applyStimulus(1'b0, 12'd1, 1'b0, 1'b0);

    // Reset asserted in the middle of CAPTURE.
    $display("[TB] reset mid-run");
    applyStimulus(1'b1, 12'd5, 1'b0, 1'b0);
    cycle();
    applyStimulus(1'b0, 12'd5, 1'b1, 1'b1);
    cycle();
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_sig", sig, 16'h0000);
    checkOutput("mid_rst_busy", busy, 1'b0);
    checkOutput("mid_rst_done", done, 1'b0);
    checkOutput("mid_rst_pass", pass, 1'b0);
    applyStimulus(1'b0, 12'd5, 1'b0, 1'b0);
    cycle();
    rst_n = 1'b1;
    cycle();

    // Maximum window with random data and random stalls against the model.
    $display("[TB] maximum window with random data");
    model      = 16'h0000;
    accepted   = 0;
    early_done = 0;
    budget     = 0;
    applyStimulus(1'b1, 12'd4095, 1'b0, 1'b0);
    cycle();
    while (accepted < 4095 && budget < 20000) begin
      if (done) early_done++;
      vld_r = ($urandom_range(0, 3) != 0);
      bit_r = 1'($urandom_range(0, 1));
      applyStimulus(1'b0, 12'd4095, vld_r, bit_r);
      if (vld_r) begin
        model = misr_step(model, bit_r);
        accepted++;
      end
      exp_sig = model;
      budget++;
      cycle();
    end
    checkOutput("max_within_budget", (accepted == 4095) ? 1 : 0, 1);
    checkOutput("max_no_early_done", early_done, 0);
    applyStimulus(1'b0, 12'd4095, 1'b0, 1'b0);
    checkOutput("max_done", done, 1'b1);
    checkOutput("max_sig", sig, model);
    cycle();
    checkOutput("max_done_once", done, 1'b0);
    checkOutput("max_pass", pass, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
